// File: rtl/wb_result_streamer_pkg.sv
// Shared definitions for the writeback result streamer: FSM states, tag marker, FIFO entry layout.
package wb_result_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_TAG = 2'd1,
    ST_SEND_LO  = 2'd2,
    ST_SEND_HI  = 2'd3
  } state_t;

  localparam logic [2:0]  TAG_MARK = 3'b101;
  localparam int unsigned ENTRY_W  = 21;

  // One captured writeback: destination register above the 16-bit result.
  typedef struct packed {
    logic [4:0]  rd;
    logic [15:0] data;
  } entry_t;

  function automatic logic [7:0] tag_byte(input logic [4:0] rd);
    return {TAG_MARK, rd};
  endfunction

endpackage

// File: rtl/wb_result_streamer_sync_fifo.sv
// Single-clock FIFO holding writeback entries; push while full is only taken alongside a pop.
module sync_fifo
  import wb_result_streamer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [ADDR_W:0]    level
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (level == (ADDR_W+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage array; written only at the tail so the head stays stable during a frame.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH; level tracks occupancy on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/wb_result_streamer.sv
// Captures writeback results into a FIFO and streams them as tag/lo/hi bytes over valid/ready.
module wb_result_streamer
  import wb_result_streamer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned TAG_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  input  logic [4:0]        in_reg,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf,
  input  logic              clr_ovf,
  output logic [ADDR_W:0]   level
);

  state_t             state_q;
  state_t             state_d;
  state_t             first_st;
  entry_t             head;
  entry_t             wr_entry;
  logic [ENTRY_W-1:0] fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               drop;

  assign first_st = (TAG_EN != 0) ? ST_SEND_TAG : ST_SEND_LO;
  assign push_req = in_valid && (in_reg != '0);
  assign pop      = (state_q == ST_SEND_HI) && out_ready;
  assign push_ok  = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;
  assign wr_entry = '{rd: in_reg, data: in_data};
  assign head     = fifo_rd;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state; after HI the next frame starts at once if anything remains (including a same-edge push).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (!fifo_empty) state_d = first_st;
      ST_SEND_TAG: if (out_ready)   state_d = ST_SEND_LO;
      ST_SEND_LO:  if (out_ready)   state_d = ST_SEND_HI;
      ST_SEND_HI: begin
        if (out_ready) begin
          if ((level > (ADDR_W+1)'(1)) || push_ok) state_d = first_st;
          else                                      state_d = ST_IDLE;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output byte mux driven purely by state and the stable head entry.
  always_comb begin
    out_valid = 1'b1;
    out_byte  = 8'h00;
    case (state_q)
      ST_SEND_TAG: out_byte = tag_byte(head.rd);
      ST_SEND_LO:  out_byte = head.data[7:0];
      ST_SEND_HI:  out_byte = head.data[15:8];
      default:     out_valid = 1'b0;
    endcase
  end

  // Sticky overflow; a drop on the same edge wins over clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

endmodule
